// File: rtl/hpi_pkg.sv
// Shared definitions for the HPI bus master: FSM state encoding and the
// CY7C67200 HPI register select codes carried on A[1:0].
package hpi_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    STROBE  = 3'd2,
    HOLD    = 3'd3,
    DONE    = 3'd4,
    RECOVER = 3'd5
  } hpi_state_t;

  localparam logic [1:0] HPI_REG_DATA    = 2'd0;
  localparam logic [1:0] HPI_REG_MAILBOX = 2'd1;
  localparam logic [1:0] HPI_REG_ADDRESS = 2'd2;
  localparam logic [1:0] HPI_REG_STATUS  = 2'd3;

endpackage

// File: rtl/hpi_sync2.sv
// Two-flop synchronizer for the asynchronous HPI interrupt pin.
// Only instantiated when HPI_INT_SYNC_EN is defined.
module hpi_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops give the first stage a full cycle to settle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/hpi_bus_master.sv
// HPI bus master: turns each Avalon-MM read or write into exactly one timed
// CY7C67200 HPI bus cycle (IDLE -> SETUP -> STROBE -> HOLD -> DONE -> RECOVER).
// All outputs are registered; the tri-state buffer lives in the top level.
// Optional build macro: HPI_INT_SYNC_EN (irq through a 2-flop synchronizer).
module hpi_bus_master
  import hpi_pkg::*;
#(
  parameter int SETUP_CYC    = 1,
  parameter int STROBE_CYC   = 4,
  parameter int HOLD_CYC     = 1,
  parameter int RECOVERY_CYC = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  avs_address,
  input  logic        avs_chipselect,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [15:0] avs_writedata,
  output logic [15:0] avs_readdata,
  output logic        avs_waitrequest,
  output logic [1:0]  otg_hpi_address,
  output logic        otg_hpi_cs_n,
  output logic        otg_hpi_r_n,
  output logic        otg_hpi_w_n,
  input  logic [15:0] otg_hpi_data_in,
  output logic [15:0] otg_hpi_data_out,
  output logic        otg_hpi_data_oe,
  input  logic        otg_hpi_int,
  output logic        irq
);

  // One phase counter serves every timed state, so size it for the longest.
  localparam int MAX_SS  = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int MAX_HR  = (HOLD_CYC > RECOVERY_CYC) ? HOLD_CYC : RECOVERY_CYC;
  localparam int MAX_CYC = (MAX_SS > MAX_HR) ? MAX_SS : MAX_HR;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  hpi_state_t       state_q;
  hpi_state_t       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             is_write_q;
  logic             req;
  logic             accept;
  logic             phase_end;
  logic             dir_d;
  logic             active_d;
  logic             cs_n_d;
  logic             r_n_d;
  logic             w_n_d;
  logic             oe_d;
  logic             wait_d;

  // Counter reload on state entry: the counter runs n-1 .. 0, so the state
  // lasts n cycles. States that are skipped (n=0) never load it.
  function automatic logic [CNT_W-1:0] reload(input hpi_state_t s);
    int n;
    case (s)
      SETUP:   n = SETUP_CYC;
      STROBE:  n = STROBE_CYC;
      HOLD:    n = HOLD_CYC;
      RECOVER: n = RECOVERY_CYC;
      default: n = 1;
    endcase
    return (n > 0) ? CNT_W'(n - 1) : '0;
  endfunction

  assign req       = avs_chipselect & (avs_read | avs_write);
  assign accept    = (state_q == IDLE) & req;
  assign phase_end = (cnt_q == '0);

  // A request arriving this cycle decides the direction of the new bus cycle;
  // write wins when read and write are both asserted.
  assign dir_d = accept ? avs_write : is_write_q;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: zero-length SETUP/HOLD/RECOVER phases are skipped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = (SETUP_CYC > 0) ? SETUP : STROBE;
      SETUP:   if (phase_end) state_d = STROBE;
      STROBE:  if (phase_end) state_d = (HOLD_CYC > 0) ? HOLD : DONE;
      HOLD:    if (phase_end) state_d = DONE;
      DONE:    state_d = (RECOVERY_CYC > 0) ? RECOVER : IDLE;
      RECOVER: if (phase_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Phase counter: reload on every state entry, otherwise count down to 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (state_d != state_q) begin
      cnt_q <= reload(state_d);
    end else if (!phase_end) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // Latch the direction of the accepted request for the rest of the cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       is_write_q <= 1'b0;
    else if (accept) is_write_q <= avs_write;
  end

  // Output decode from the state being entered, so the pins are registered
  // yet line up exactly with the state they belong to.
  always_comb begin
    active_d = 1'b0;
    if (state_d inside {SETUP, STROBE, HOLD}) active_d = 1'b1;
    cs_n_d = ~active_d;
    r_n_d  = ~((state_d == STROBE) & ~dir_d);
    w_n_d  = ~((state_d == STROBE) & dir_d);
    oe_d   = active_d & dir_d;
    wait_d = (state_d != DONE);
  end

  // Registered HPI strobes, bus enable and Avalon stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      otg_hpi_cs_n    <= 1'b1;
      otg_hpi_r_n     <= 1'b1;
      otg_hpi_w_n     <= 1'b1;
      otg_hpi_data_oe <= 1'b0;
      avs_waitrequest <= 1'b1;
    end else begin
      otg_hpi_cs_n    <= cs_n_d;
      otg_hpi_r_n     <= r_n_d;
      otg_hpi_w_n     <= w_n_d;
      otg_hpi_data_oe <= oe_d;
      avs_waitrequest <= wait_d;
    end
  end

  // Address and write data are captured at acceptance and held unchanged
  // through SETUP, STROBE and HOLD.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      otg_hpi_address  <= 2'd0;
      otg_hpi_data_out <= 16'd0;
    end else if (accept) begin
      otg_hpi_address <= avs_address;
      if (avs_write) otg_hpi_data_out <= avs_writedata;
    end
  end

  // Read data is sampled on the edge that ends the last STROBE cycle and is
  // then held, so write cycles leave it untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      avs_readdata <= 16'd0;
    end else if ((state_q == STROBE) && phase_end && !is_write_q) begin
      avs_readdata <= otg_hpi_data_in;
    end
  end

`ifdef HPI_INT_SYNC_EN
  hpi_sync2 u_int_sync (
    .clk  (clk),
    .reset(reset),
    .d    (otg_hpi_int),
    .q    (irq)
  );
`else
  // Single register of the interrupt pin.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq <= 1'b0;
    else       irq <= otg_hpi_int;
  end
`endif

endmodule

// File: tb/tb_hpi_bus_master.sv
// Bench for hpi_bus_master: a default-timing instance (A) and a minimal-timing
// instance (B, SETUP=0 STROBE=1 HOLD=0 RECOVERY=0). Expected pin behaviour is
// derived from the bus-cycle timeline: cycle k=1 is the first cs_n-low cycle.
module tb_hpi_bus_master;
  import hpi_pkg::*;

  localparam int A_S = 1, A_T = 4, A_H = 1, A_R = 2;
  localparam int B_S = 0, B_T = 1, B_H = 0, B_R = 0;
`ifdef HPI_INT_SYNC_EN
  localparam int IRQ_LAT = 2;
`else
  localparam int IRQ_LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        a_cs, b_cs;
  logic        avs_read, avs_write;
  logic [1:0]  avs_address;
  logic [15:0] avs_writedata;
  logic [15:0] data_in;
  logic        hpi_int;

  logic [15:0] a_readdata, b_readdata, a_dout, b_dout;
  logic        a_wait, b_wait, a_cs_n, b_cs_n, a_r_n, b_r_n, a_w_n, b_w_n;
  logic        a_oe, b_oe, a_irq, b_irq;
  logic [1:0]  a_addr, b_addr;

  logic        sel;
  logic [15:0] m_readdata, m_dout;
  logic        m_wait, m_cs_n, m_r_n, m_w_n, m_oe;
  logic [1:0]  m_addr;

  int          n_err = 0;
  int          n_checks = 0;
  logic [15:0] rd_model [2];

  always #5 clk = ~clk;

  hpi_bus_master #(.SETUP_CYC(A_S), .STROBE_CYC(A_T), .HOLD_CYC(A_H), .RECOVERY_CYC(A_R)) dut_a (
    .clk(clk), .reset(reset), .avs_address(avs_address), .avs_chipselect(a_cs),
    .avs_read(avs_read), .avs_write(avs_write), .avs_writedata(avs_writedata),
    .avs_readdata(a_readdata), .avs_waitrequest(a_wait), .otg_hpi_address(a_addr),
    .otg_hpi_cs_n(a_cs_n), .otg_hpi_r_n(a_r_n), .otg_hpi_w_n(a_w_n),
    .otg_hpi_data_in(data_in), .otg_hpi_data_out(a_dout), .otg_hpi_data_oe(a_oe),
    .otg_hpi_int(hpi_int), .irq(a_irq)
  );

  hpi_bus_master #(.SETUP_CYC(B_S), .STROBE_CYC(B_T), .HOLD_CYC(B_H), .RECOVERY_CYC(B_R)) dut_b (
    .clk(clk), .reset(reset), .avs_address(avs_address), .avs_chipselect(b_cs),
    .avs_read(avs_read), .avs_write(avs_write), .avs_writedata(avs_writedata),
    .avs_readdata(b_readdata), .avs_waitrequest(b_wait), .otg_hpi_address(b_addr),
    .otg_hpi_cs_n(b_cs_n), .otg_hpi_r_n(b_r_n), .otg_hpi_w_n(b_w_n),
    .otg_hpi_data_in(data_in), .otg_hpi_data_out(b_dout), .otg_hpi_data_oe(b_oe),
    .otg_hpi_int(hpi_int), .irq(b_irq)
  );

  always_comb begin
    m_readdata = sel ? b_readdata : a_readdata;
    m_dout     = sel ? b_dout     : a_dout;
    m_wait     = sel ? b_wait     : a_wait;
    m_cs_n     = sel ? b_cs_n     : a_cs_n;
    m_r_n      = sel ? b_r_n      : a_r_n;
    m_w_n      = sel ? b_w_n      : a_w_n;
    m_oe       = sel ? b_oe       : a_oe;
    m_addr     = sel ? b_addr     : a_addr;
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Issue one request at the current (negedge) point and follow the bus cycle.
  // exp_lead = cycles from request to the first cs_n-low cycle.
  task automatic run_txn(input logic s, input logic wr, input logic rd,
                         input logic [1:0] a, input logic [15:0] wd,
                         input logic [15:0] din, input logic stable,
                         input int exp_lead);
    int S, T, H, L, span, lead;
    logic [15:0] exp_rd;
    S = s ? B_S : A_S;
    T = s ? B_T : A_T;
    H = s ? B_H : A_H;
    span = S + T + H;
    L = span + 1;
    exp_rd = wr ? rd_model[s] : din;
    sel = s;
    if (s) b_cs = 1'b1; else a_cs = 1'b1;
    avs_read = rd;
    avs_write = wr;
    avs_address = a;
    avs_writedata = wd;
    data_in = stable ? din : ~din;
    lead = 0;
    do begin
      tick();
      lead++;
      if (m_cs_n !== 1'b0) chk1("stall_before_cycle", m_wait, 1'b1);
    end while (m_cs_n !== 1'b0 && lead < 20);
    chk16("lead", 16'(lead), 16'(exp_lead));
    if (m_cs_n === 1'b0) begin
      for (int k = 1; k <= L; k++) begin
        if (k > 1) tick();
        data_in = (stable || k == S + T) ? din : ~din;
        chk1("cs_n", m_cs_n, (k <= span) ? 1'b0 : 1'b1);
        chk1("r_n", m_r_n, !((k > S) && (k <= S + T) && !wr));
        chk1("w_n", m_w_n, !((k > S) && (k <= S + T) && wr));
        chk1("oe", m_oe, wr && (k <= span));
        chk1("waitrequest", m_wait, (k == L) ? 1'b0 : 1'b1);
        if (k <= span) begin
          chk16("hpi_address", {14'd0, m_addr}, {14'd0, a});
          if (wr) chk16("data_out", m_dout, wd);
        end
        if (k == L) chk16("readdata", m_readdata, exp_rd);
      end
    end
    rd_model[s] = exp_rd;
    a_cs = 1'b0;
    b_cs = 1'b0;
    avs_read = 1'b0;
    avs_write = 1'b0;
  endtask

  // Walk through RECOVER into IDLE, checking the bus stays idle and stalled.
  task automatic recover(input logic s);
    int R;
    R = s ? B_R : A_R;
    sel = s;
    for (int k = 0; k <= R; k++) begin
      tick();
      chk1("recover_cs_n", m_cs_n, 1'b1);
      chk1("recover_wait", m_wait, 1'b1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    a_cs = 1'b0; b_cs = 1'b0;
    avs_read = 1'b0; avs_write = 1'b0;
    avs_address = 2'd0; avs_writedata = 16'd0;
    data_in = 16'd0; hpi_int = 1'b0; sel = 1'b0;
    rd_model[0] = 16'd0; rd_model[1] = 16'd0;
    tick();
    tick();

    // Reset values
    chk1("rst_cs_n", a_cs_n, 1'b1);
    chk1("rst_r_n", a_r_n, 1'b1);
    chk1("rst_w_n", a_w_n, 1'b1);
    chk1("rst_oe", a_oe, 1'b0);
    chk16("rst_address", {14'd0, a_addr}, 16'd0);
    chk16("rst_data_out", a_dout, 16'd0);
    chk16("rst_readdata", a_readdata, 16'd0);
    chk1("rst_wait", a_wait, 1'b1);
    chk1("rst_irq", a_irq, 1'b0);
    chk1("rst_wait_b", b_wait, 1'b1);
    reset = 1'b0;
    tick();

    // Directed write, read, back-to-back, minimal timing, read+write collision
    run_txn(1'b0, 1'b1, 1'b0, HPI_REG_ADDRESS, 16'h1234, 16'h0000, 1'b1, 1);
    recover(1'b0);
    run_txn(1'b0, 1'b0, 1'b1, HPI_REG_DATA, 16'h0000, 16'hBEEF, 1'b1, 1);
    recover(1'b0);
    run_txn(1'b0, 1'b1, 1'b0, HPI_REG_MAILBOX, 16'hC0DE, 16'h0000, 1'b1, 1);
    run_txn(1'b0, 1'b0, 1'b1, HPI_REG_STATUS, 16'h0000, 16'h8001, 1'b1, A_R + 2);
    recover(1'b0);
    run_txn(1'b1, 1'b0, 1'b1, HPI_REG_DATA, 16'h0000, 16'h1357, 1'b0, 1);
    recover(1'b1);
    run_txn(1'b0, 1'b1, 1'b1, HPI_REG_MAILBOX, 16'h00A5, 16'hFFFF, 1'b0, 1);
    recover(1'b0);

    // Interrupt pin to irq latency, rising then falling
    hpi_int = 1'b1;
    for (int k = 1; k <= IRQ_LAT + 1; k++) begin
      tick();
      chk1("irq_rise_a", a_irq, (k >= IRQ_LAT));
      chk1("irq_rise_b", b_irq, (k >= IRQ_LAT));
    end
    hpi_int = 1'b0;
    for (int k = 1; k <= IRQ_LAT + 1; k++) begin
      tick();
      chk1("irq_fall_a", a_irq, (k < IRQ_LAT));
    end

    // Randomized transactions on both timing configurations
    for (int i = 0; i < 16; i++) begin
      logic s, wr, rd;
      s  = i[0];
      wr = 1'($urandom_range(0, 1));
      rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      run_txn(s, wr, rd, 2'($urandom), 16'($urandom), 16'($urandom),
              1'($urandom_range(0, 1)), 1);
      recover(s);
    end

    // Reset asserted during STROBE of a write
    sel = 1'b0;
    a_cs = 1'b1; avs_write = 1'b1; avs_read = 1'b0;
    avs_address = HPI_REG_DATA; avs_writedata = 16'h5A5A;
    tick();
    tick();
    tick();
    chk1("pre_reset_w_n", a_w_n, 1'b0);
    reset = 1'b1;
    #1;
    chk1("async_rst_cs_n", a_cs_n, 1'b1);
    chk1("async_rst_w_n", a_w_n, 1'b1);
    chk1("async_rst_oe", a_oe, 1'b0);
    a_cs = 1'b0; avs_write = 1'b0;
    rd_model[0] = 16'd0; rd_model[1] = 16'd0;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk1("post_reset_wait", a_wait, 1'b1);
      chk1("post_reset_cs_n", a_cs_n, 1'b1);
    end
    chk16("post_reset_readdata", a_readdata, rd_model[0]);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/hpi_bus_master.md
Name: hpi_bus_master

Overview:
- Hardware transaction engine that drives the CY7C67200 HPI pins directly: the pin-level end of the HPI path.
- Replaces bit-banging of separate address/data/cs/rd/wr PIOs from software with a single Avalon-MM slave.
- One Avalon read or write produces exactly one timed HPI bus cycle.
- Sits in final_soc between the Nios II data master and the top-level OTG pins; the top level owns the tri-state buffer.

Parameters:
- SETUP_CYC, 1: cycles with cs_n low and address/data stable before the strobe; 0 skips SETUP.
- STROBE_CYC, 4: cycles r_n/w_n is held low; minimum 1.
- HOLD_CYC, 1: cycles after the strobe rises with cs_n low and address/data held; 0 skips HOLD.
- RECOVERY_CYC, 2: idle cycles with cs_n high before the next cycle may start; 0 skips RECOVER.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- avs_address  in  2  HPI register select: 0 DATA, 1 MAILBOX, 2 ADDRESS, 3 STATUS
- avs_chipselect  in  1  Avalon slave select
- avs_read  in  1  read request
- avs_write  in  1  write request
- avs_writedata  in  16  write data
- avs_readdata  out  16  read data, valid when waitrequest=0 on a read
- avs_waitrequest  out  1  Avalon stall
- otg_hpi_address  out  2  HPI A[1:0]
- otg_hpi_cs_n  out  1  HPI chip select, active low
- otg_hpi_r_n  out  1  HPI read strobe, active low
- otg_hpi_w_n  out  1  HPI write strobe, active low
- otg_hpi_data_in  in  16  sampled HPI data bus
- otg_hpi_data_out  out  16  driven HPI data
- otg_hpi_data_oe  out  1  1 = top level drives otg_hpi_data_out onto the pins
- otg_hpi_int  in  1  HPI interrupt pin (asynchronous)
- irq  out  1  interrupt to the CPU

Behaviour:
- One clock (clk). Reset is asynchronous and active-high (reset).
- All outputs are registered.
- Reset values:
  - cs_n, r_n, w_n = 1
  - oe = 0
  - address = 0, data_out = 0
  - readdata = 0
  - waitrequest = 1
  - irq = 0
  - state = IDLE
- States: IDLE -> SETUP -> STROBE -> HOLD -> DONE -> RECOVER -> IDLE.
- IDLE:
  - cs_n, r_n, w_n = 1; oe = 0.
  - On chipselect & (read | write): latch address, writedata and direction.
  - If read and write are both high, the cycle is a write.
  - Next cycle enters SETUP, or STROBE if SETUP_CYC=0.
- SETUP: cs_n=0; address driven; oe=1 for a write; lasts SETUP_CYC cycles.
- STROBE:
  - r_n=0 for a read, w_n=0 for a write; lasts STROBE_CYC cycles.
  - Read data is captured from otg_hpi_data_in on the clock edge that ends the last STROBE cycle.
- HOLD: strobes high; cs_n=0; address and data still driven; lasts HOLD_CYC cycles.
- DONE:
  - Exactly 1 cycle; cs_n=1; oe=0.
  - avs_waitrequest=0 for exactly this cycle; avs_readdata holds the captured word.
- RECOVER: cs_n=1 for RECOVERY_CYC cycles. New requests are stalled (waitrequest=1) and not accepted.
- Latency: request seen in IDLE to waitrequest low = 1+SETUP_CYC+STROBE_CYC+HOLD_CYC cycles. With defaults this is 7; DONE is cycle 7.
- waitrequest is 1 in every state except DONE.
- Request withdrawn mid-cycle (illegal on Avalon): the bus cycle still completes; the DONE pulse is harmless.
- avs_readdata is unchanged by write cycles.
- Phase counters: single down-counter of width $clog2(max param)+1, reloaded on every state entry.
- irq = registered otg_hpi_int, active-high copy.
- Reset mid-cycle: cs_n/r_n/w_n return to 1 and oe to 0 immediately (asynchronously); the aborted transaction is not completed.

Optional Feature:
- Macro: HPI_INT_SYNC_EN.
- Defined:
  - otg_hpi_int passes through a 2-flop synchronizer (reset 0); irq is the synchronized value.
  - A read of address 3 with bit 15 of the HPI STATUS word... is not altered; the synchronizer affects irq only.
  - irq latency: 2 cycles.
- Undefined: irq is a single register of otg_hpi_int; latency 1 cycle.

Decomposition:
- Package hpi_pkg holds:
  - state enum typedef hpi_state_t (IDLE, SETUP, STROBE, HOLD, DONE, RECOVER)
  - register select constants HPI_REG_DATA=0, HPI_REG_MAILBOX=1, HPI_REG_ADDRESS=2, HPI_REG_STATUS=3
- One natural sub-module: hpi_sync2, the 2-flop synchronizer, instantiated only under HPI_INT_SYNC_EN.
- The FSM and counter stay in the top module.

Test Plan:
- Reset mid-STROBE of a write (assert reset at cycle 3):
  - cs_n=w_n=1 and oe=0 in the same cycle, before any clock edge.
  - After release: waitrequest=1, IDLE, no DONE pulse.
- Write, defaults, address=2, writedata=16'h1234:
  - cs_n low cycles 1-6; w_n low cycles 2-5.
  - otg_hpi_address=2 and data_out=16'h1234 with oe=1 throughout cycles 1-6.
  - waitrequest low only in cycle 7.
- Read, address=0, data_in=16'hBEEF stable during STROBE:
  - r_n low 4 cycles; oe never 1.
  - readdata=16'hBEEF when waitrequest=0.
- Back-to-back write then read held asserted:
  - Second cycle's cs_n falls no earlier than 1+RECOVERY_CYC (=3) cycles after DONE.
  - Request is not accepted during RECOVER.
- Params SETUP_CYC=0, HOLD_CYC=0, RECOVERY_CYC=0, STROBE_CYC=1, read:
  - waitrequest low at cycle 2.
  - Data captured at the end of the single strobe cycle.
- read=write=1 at address 1, data 16'h00A5: executes as a write (w_n low, r_n stays 1); readdata unchanged.
- otg_hpi_int pulse 0->1: irq rises after 1 cycle, or after 2 cycles with HPI_INT_SYNC_EN defined.
